// File: rtl/camera_capture_multi.sv
// DVP camera capture: syncs the camera bus, assembles BYTES_PER_PIXEL bytes per pixel, tracks
// line/frame framing, generates XCLK and the camera power-up release. Optional build macro: CAMERA_CAPTURE_DECIM_EN.
module camera_capture_multi #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_ACTIVE        = 320,
  parameter int V_ACTIVE        = 240,
  parameter bit VSYNC_ACT_HIGH  = 1'b1,
  parameter int XCLK_DIV        = 8,
  parameter int STARTUP_DELAY   = 74_250_000
) (
  input  logic                         clk_pixel_in,
  input  logic                         rst_n_in,
  input  logic                         cam_clk_in,
  input  logic                         vsync_in,
  input  logic                         href_in,
  input  logic [7:0]                   pixel_in,
`ifdef CAMERA_CAPTURE_DECIM_EN
  input  logic                         decim_in,
`endif
  output logic                         pmodbclk,
  output logic                         pmodblock,
  output logic [8*BYTES_PER_PIXEL-1:0] pixel_out,
  output logic                         pixel_valid_out,
  output logic [$clog2(H_ACTIVE)-1:0]  hcount_out,
  output logic [$clog2(V_ACTIVE)-1:0]  vcount_out,
  output logic                         line_done_out,
  output logic                         frame_done_out,
  output logic                         frame_err_out
);

  localparam int PW  = 8 * BYTES_PER_PIXEL;
  localparam int HW  = $clog2(H_ACTIVE);
  localparam int VW  = $clog2(V_ACTIVE);
  localparam int HCW = $clog2(H_ACTIVE + 1);
  localparam int LCW = $clog2(V_ACTIVE + 2);
  localparam int BIW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int XCW = $clog2(XCLK_DIV);
  localparam int SCW = $clog2(STARTUP_DELAY + 1);

  localparam logic [HCW-1:0] H_MAX   = HCW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_ACTIVE - 1);
  localparam logic [LCW-1:0] L_EXP   = LCW'(V_ACTIVE);
  localparam logic [LCW-1:0] L_SAT   = LCW'(V_ACTIVE + 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(BYTES_PER_PIXEL - 1);
  localparam logic [XCW-1:0] XC_LAST = XCW'(XCLK_DIV - 1);
  localparam logic [XCW-1:0] XC_HALF = XCW'(XCLK_DIV / 2);
  localparam logic [SCW-1:0] SD_LAST = SCW'(STARTUP_DELAY - 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_WAIT_FRAME, ST_CAPTURE} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cam_sync_q, cam_sync_d;
  logic [1:0]     vs_sync_q, vs_sync_d, href_sync_q, href_sync_d;
  logic [7:0]     pix_s1_q, pix_s1_d, pix_s2_q, pix_s2_d;
  logic [XCW-1:0] xclk_cnt_q, xclk_cnt_d;
  logic [SCW-1:0] start_cnt_q, start_cnt_d;
  logic           pmodbclk_q, pmodbclk_d, pmodblock_q, pmodblock_d;
  logic           vs_prev_q, vs_prev_d, href_prev_q, href_prev_d;
  logic [BIW-1:0] byte_idx_q, byte_idx_d;
  logic [PW-1:0]  asm_q, asm_d;
  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VW-1:0]  vcount_q, vcount_d;
  logic [LCW-1:0] lines_q, lines_d;
  logic           decim_q, decim_d;
  logic           emit_q, emit_d, line_ev_q, line_ev_d;
  logic           frame_ev_q, frame_ev_d, err_ev_q, err_ev_d;
  logic [PW-1:0]  emit_pix_q, emit_pix_d;
  logic [HW-1:0]  emit_h_q, emit_h_d;
  logic [VW-1:0]  emit_v_q, emit_v_d;
  logic           pixel_valid_q, pixel_valid_d, line_done_q, line_done_d;
  logic           frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [PW-1:0]  pixel_out_q, pixel_out_d;
  logic [HW-1:0]  hcount_out_q, hcount_out_d;
  logic [VW-1:0]  vcount_out_q, vcount_out_d;

  logic pclk_rise, vs_blank, href_s, decim_src;

`ifdef CAMERA_CAPTURE_DECIM_EN
  assign decim_src = decim_in;
`else
  assign decim_src = 1'b0;
`endif

  assign pclk_rise = cam_sync_q[1] & ~cam_sync_q[2];
  assign vs_blank  = VSYNC_ACT_HIGH ? vs_sync_q[1] : ~vs_sync_q[1];
  assign href_s    = href_sync_q[1];

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    cam_sync_d  = {cam_sync_q[1:0], cam_clk_in};
    vs_sync_d   = {vs_sync_q[0], vsync_in};
    href_sync_d = {href_sync_q[0], href_in};
    pix_s1_d    = pixel_in;
    pix_s2_d    = pix_s1_q;
    xclk_cnt_d  = (xclk_cnt_q == XC_LAST) ? '0 : xclk_cnt_q + 1'b1;
    pmodbclk_d  = (xclk_cnt_d >= XC_HALF);

    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    pmodblock_d = pmodblock_q;
    vs_prev_d   = vs_prev_q;
    href_prev_d = href_prev_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    lines_d     = lines_q;
    decim_d     = decim_q;
    emit_d      = 1'b0;
    line_ev_d   = 1'b0;
    frame_ev_d  = 1'b0;
    err_ev_d    = 1'b0;
    emit_pix_d  = emit_pix_q;
    emit_h_d    = emit_h_q;
    emit_v_d    = emit_v_q;

    if (pclk_rise) begin
      vs_prev_d   = vs_blank;
      href_prev_d = href_s;
    end

    unique case (state_q)
      ST_STARTUP: begin
        if (start_cnt_q == SD_LAST) begin
          pmodblock_d = 1'b1;
          state_d     = ST_WAIT_FRAME;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      ST_WAIT_FRAME: begin
        // Only a blank->active edge starts a frame; joining mid-frame waits for the next one.
        if (pclk_rise && !vs_blank && vs_prev_q) begin
          state_d    = ST_CAPTURE;
          byte_idx_d = '0;
          hcount_d   = '0;
          vcount_d   = '0;
          lines_d    = '0;
          decim_d    = decim_src;
        end
      end
      ST_CAPTURE: begin
        if (pclk_rise) begin
          if (vs_blank) begin
            frame_ev_d = 1'b1;
            err_ev_d   = href_s || (lines_q != L_EXP);
            state_d    = ST_WAIT_FRAME;
          end else if (href_s) begin
            asm_d = PW'({asm_q, pix_s2_q});
            if (byte_idx_q == BI_LAST) begin
              byte_idx_d = '0;
              if (hcount_q == H_MAX) begin
                err_ev_d = 1'b1;
              end else begin
                hcount_d   = hcount_q + 1'b1;
                emit_d     = !decim_q || (!hcount_q[0] && !vcount_q[0]);
                emit_pix_d = asm_d;
                emit_h_d   = HW'(decim_q ? (hcount_q >> 1) : hcount_q);
                emit_v_d   = decim_q ? (vcount_q >> 1) : vcount_q;
              end
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else if (href_prev_q) begin
            line_ev_d  = 1'b1;
            err_ev_d   = (byte_idx_q != '0) || (hcount_q != H_MAX);
            hcount_d   = '0;
            byte_idx_d = '0;
            if (vcount_q != V_LAST) vcount_d = vcount_q + 1'b1;
            if (lines_q != L_SAT)   lines_d  = lines_q + 1'b1;
          end
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    pixel_valid_d = emit_q;
    line_done_d   = line_ev_q;
    frame_done_d  = frame_ev_q;
    frame_err_d   = err_ev_q;
    pixel_out_d   = emit_q ? emit_pix_q : pixel_out_q;
    hcount_out_d  = emit_q ? emit_h_q : hcount_out_q;
    vcount_out_d  = emit_q ? emit_v_q : vcount_out_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_STARTUP;
      cam_sync_q    <= '0;
      vs_sync_q     <= '0;
      href_sync_q   <= '0;
      pix_s1_q      <= '0;
      pix_s2_q      <= '0;
      xclk_cnt_q    <= '0;
      start_cnt_q   <= '0;
      pmodbclk_q    <= 1'b0;
      pmodblock_q   <= 1'b0;
      vs_prev_q     <= 1'b0;
      href_prev_q   <= 1'b0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      lines_q       <= '0;
      decim_q       <= 1'b0;
      emit_q        <= 1'b0;
      line_ev_q     <= 1'b0;
      frame_ev_q    <= 1'b0;
      err_ev_q      <= 1'b0;
      emit_pix_q    <= '0;
      emit_h_q      <= '0;
      emit_v_q      <= '0;
      pixel_valid_q <= 1'b0;
      line_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      pixel_out_q   <= '0;
      hcount_out_q  <= '0;
      vcount_out_q  <= '0;
    end else begin
      state_q       <= state_d;
      cam_sync_q    <= cam_sync_d;
      vs_sync_q     <= vs_sync_d;
      href_sync_q   <= href_sync_d;
      pix_s1_q      <= pix_s1_d;
      pix_s2_q      <= pix_s2_d;
      xclk_cnt_q    <= xclk_cnt_d;
      start_cnt_q   <= start_cnt_d;
      pmodbclk_q    <= pmodbclk_d;
      pmodblock_q   <= pmodblock_d;
      vs_prev_q     <= vs_prev_d;
      href_prev_q   <= href_prev_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      lines_q       <= lines_d;
      decim_q       <= decim_d;
      emit_q        <= emit_d;
      line_ev_q     <= line_ev_d;
      frame_ev_q    <= frame_ev_d;
      err_ev_q      <= err_ev_d;
      emit_pix_q    <= emit_pix_d;
      emit_h_q      <= emit_h_d;
      emit_v_q      <= emit_v_d;
      pixel_valid_q <= pixel_valid_d;
      line_done_q   <= line_done_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      pixel_out_q   <= pixel_out_d;
      hcount_out_q  <= hcount_out_d;
      vcount_out_q  <= vcount_out_d;
    end
  end

  assign pmodbclk        = pmodbclk_q;
  assign pmodblock       = pmodblock_q;
  assign pixel_out       = pixel_out_q;
  assign pixel_valid_out = pixel_valid_q;
  assign hcount_out      = hcount_out_q;
  assign vcount_out      = vcount_out_q;
  assign line_done_out   = line_done_q;
  assign frame_done_out  = frame_done_q;
  assign frame_err_out   = frame_err_q;

endmodule

// File: tb/tb_camera_capture_multi.sv
// Directed bench for camera_capture_multi: three instances (BPP=2, BPP=3, BPP=1 decimation)
// each driven from its own camera pins with a slow PCLK.
`timescale 1ns/1ps
module tb_camera_capture_multi;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cam_clk [NI];
  logic       vsync   [NI];
  logic       href    [NI];
  logic       decim   [NI];
  logic [7:0] pix     [NI];

  logic        bclk2, block2, pv2, ld2, fd2, fe2;
  logic [15:0] po2;
  logic [1:0]  hc2;
  logic [0:0]  vc2;
  logic        bclk3, block3, pv3, ld3, fd3, fe3;
  logic [23:0] po3;
  logic [1:0]  hc3;
  logic [0:0]  vc3;
  logic        bclkd, blockd, pvd, ldd, fdd, fed;
  logic [7:0]  pod;
  logic [1:0]  hcd;
  logic [1:0]  vcd;

  camera_capture_multi #(.BYTES_PER_PIXEL(2), .H_ACTIVE(4), .V_ACTIVE(2), .VSYNC_ACT_HIGH(1'b1),
                         .XCLK_DIV(8), .STARTUP_DELAY(100)) u2 (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .cam_clk_in(cam_clk[0]), .vsync_in(vsync[0]),
    .href_in(href[0]), .pixel_in(pix[0]),
`ifdef CAMERA_CAPTURE_DECIM_EN
    .decim_in(decim[0]),
`endif
    .pmodbclk(bclk2), .pmodblock(block2), .pixel_out(po2), .pixel_valid_out(pv2),
    .hcount_out(hc2), .vcount_out(vc2), .line_done_out(ld2), .frame_done_out(fd2),
    .frame_err_out(fe2));

  camera_capture_multi #(.BYTES_PER_PIXEL(3), .H_ACTIVE(4), .V_ACTIVE(2), .VSYNC_ACT_HIGH(1'b1),
                         .XCLK_DIV(8), .STARTUP_DELAY(100)) u3 (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .cam_clk_in(cam_clk[1]), .vsync_in(vsync[1]),
    .href_in(href[1]), .pixel_in(pix[1]),
`ifdef CAMERA_CAPTURE_DECIM_EN
    .decim_in(decim[1]),
`endif
    .pmodbclk(bclk3), .pmodblock(block3), .pixel_out(po3), .pixel_valid_out(pv3),
    .hcount_out(hc3), .vcount_out(vc3), .line_done_out(ld3), .frame_done_out(fd3),
    .frame_err_out(fe3));

  camera_capture_multi #(.BYTES_PER_PIXEL(1), .H_ACTIVE(4), .V_ACTIVE(4), .VSYNC_ACT_HIGH(1'b1),
                         .XCLK_DIV(8), .STARTUP_DELAY(100)) ud (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .cam_clk_in(cam_clk[2]), .vsync_in(vsync[2]),
    .href_in(href[2]), .pixel_in(pix[2]),
`ifdef CAMERA_CAPTURE_DECIM_EN
    .decim_in(decim[2]),
`endif
    .pmodbclk(bclkd), .pmodblock(blockd), .pixel_out(pod), .pixel_valid_out(pvd),
    .hcount_out(hcd), .vcount_out(vcd), .line_done_out(ldd), .frame_done_out(fdd),
    .frame_err_out(fed));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge away from the DUT's active edge.
  int          n_pv [NI];
  int          n_ld [NI];
  int          n_fd [NI];
  int          n_fe [NI];
  int          n_fdfe [NI];
  time         last_rise [NI];
  logic [15:0] log2_pix [$];
  int          log2_h [$];
  int          log2_v [$];
  int          lat2 [$];
  logic [23:0] log3_pix [$];
  int          log3_h [$];
  int          log3_v [$];
  int          logd_h [$];
  int          logd_v [$];

  always @(negedge clk) begin
    if (pv2) begin
      n_pv[0]++;
      log2_pix.push_back(po2);
      log2_h.push_back(int'(hc2));
      log2_v.push_back(int'(vc2));
      lat2.push_back(int'(($time - last_rise[0]) / 10));
    end
    if (ld2) n_ld[0]++;
    if (fd2) n_fd[0]++;
    if (fe2) n_fe[0]++;
    if (fd2 && fe2) n_fdfe[0]++;
    if (pv3) begin
      n_pv[1]++;
      log3_pix.push_back(po3);
      log3_h.push_back(int'(hc3));
      log3_v.push_back(int'(vc3));
    end
    if (ld3) n_ld[1]++;
    if (fe3) n_fe[1]++;
    if (pvd) begin
      n_pv[2]++;
      logd_h.push_back(int'(hcd));
      logd_v.push_back(int'(vcd));
    end
    if (fed) n_fe[2]++;
  end

  logic [7:0] nb;

  // One PCLK period: data/href/vsync change with PCLK low, then PCLK rises.
  task automatic pclk(input int i, input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    cam_clk[i] = 1'b0;
    vsync[i]   = vs;
    href[i]    = hr;
    pix[i]     = d;
    repeat (4) @(negedge clk);
    cam_clk[i]   = 1'b1;
    last_rise[i] = $time;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_start(input int i);
    pclk(i, 1'b1, 1'b0, 8'h00);
    pclk(i, 1'b1, 1'b0, 8'h00);
    pclk(i, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_bytes(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      pclk(i, 1'b0, 1'b1, nb);
      nb = nb + 8'h11;
    end
  endtask

  task automatic line(input int i, input int n);
    send_bytes(i, n);
    pclk(i, 1'b0, 1'b0, 8'h00);
  endtask

  int         rise_at [2];
  int         nr, hi, base_pv, base_fd, base_fe, base_fdfe, base_ld;
  logic       prev_b;
  logic [7:0] b0, b1;

  initial begin
    for (int i = 0; i < NI; i++) begin
      cam_clk[i] = 1'b0; vsync[i] = 1'b0; href[i] = 1'b0; decim[i] = 1'b0; pix[i] = 8'h00;
      n_pv[i] = 0; n_ld[i] = 0; n_fd[i] = 0; n_fe[i] = 0; n_fdfe[i] = 0; last_rise[i] = 0;
    end
    nb = 8'h00;

    // Reset state and startup release
    repeat (3) @(negedge clk);
    check("rst_pixel_valid", pv2, 1'b0);
    check("rst_pmodblock", block2, 1'b0);
    check("rst_pmodbclk", bclk2, 1'b0);
    check("rst_pixel_out", po2, 16'h0000);
    check("rst_flags", {ld2, fd2, fe2}, 3'b000);
    rst_n = 1'b1;
    repeat (99) @(posedge clk);
    #1 check("pmodblock_cycle99", block2, 1'b0);
    @(posedge clk);
    #1 check("pmodblock_cycle100", block2, 1'b1);

    nr = 0; hi = 0; prev_b = bclk2;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bclk2 && !prev_b && nr < 2) begin
        rise_at[nr] = c;
        nr++;
      end
      if (c < 32 && bclk2) hi++;
      prev_b = bclk2;
    end
    check("xclk_period", (nr == 2) ? rise_at[1] - rise_at[0] : 0, 8);
    check("xclk_high_of_32", hi, 16);

    // 4x2 frame, 2 bytes per pixel
    frame_start(0);
    nb = 8'hA1;
    line(0, 8);
    line(0, 8);
    pclk(0, 1'b1, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    check("f2_strobes", n_pv[0], 8);
    check("f2_line_done", n_ld[0], 2);
    check("f2_frame_done", n_fd[0], 1);
    check("f2_frame_err", n_fe[0], 0);
    check("f2_first_pixel", (log2_pix.size() > 0) ? log2_pix[0] : 16'h0, 16'hA1B2);
    check("f2_latency", (lat2.size() > 0) ? lat2[0] : 0, 4);
    b0 = 8'hA1;
    for (int n = 0; n < log2_pix.size() && n < 8; n++) begin
      b1 = b0 + 8'h11;
      check($sformatf("f2_pix%0d", n), log2_pix[n], {b0, b1});
      check($sformatf("f2_h%0d", n), log2_h[n], n % 4);
      check($sformatf("f2_v%0d", n), log2_v[n], n / 4);
      b0 = b1 + 8'h11;
    end

    // BPP=3: one full pixel then a partial one cut by href fall
    frame_start(1);
    nb = 8'h11;
    line(1, 4);
    repeat (8) @(negedge clk);
    check("p3_strobes", n_pv[1], 1);
    check("p3_pixel", (log3_pix.size() > 0) ? log3_pix[0] : 24'h0, 24'h112233);
    check("p3_frame_err", n_fe[1], 1);
    check("p3_line_done", n_ld[1], 1);
    line(1, 3);
    repeat (8) @(negedge clk);
    check("p3_strobes2", n_pv[1], 2);
    check("p3_pixel2", (log3_pix.size() > 1) ? log3_pix[1] : 24'h0, 24'h556677);
    check("p3_h_after_err", (log3_h.size() > 1) ? log3_h[1] : 99, 0);
    check("p3_v_after_err", (log3_v.size() > 1) ? log3_v[1] : 99, 1);

    // vsync blanking while href high truncates the line
    base_pv = n_pv[0]; base_fd = n_fd[0]; base_fe = n_fe[0]; base_fdfe = n_fdfe[0];
    frame_start(0);
    nb = 8'h01;
    send_bytes(0, 5);
    pclk(0, 1'b1, 1'b1, 8'hEE);
    repeat (8) @(negedge clk);
    check("trunc_strobes", n_pv[0] - base_pv, 2);
    check("trunc_frame_done", n_fd[0] - base_fd, 1);
    check("trunc_frame_err", n_fe[0] - base_fe, 1);
    check("trunc_same_cycle", n_fdfe[0] - base_fdfe, 1);
    for (int k = 0; k < 4; k++) pclk(0, 1'b1, 1'b1, 8'h5A);
    pclk(0, 1'b1, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    check("trunc_idle_strobes", n_pv[0] - base_pv, 2);
    check("trunc_idle_frame_done", n_fd[0] - base_fd, 1);

    // Reset asserted and released mid-frame
    @(negedge clk);
    vsync[0] = 1'b0;
    href[0]  = 1'b0;
    rst_n    = 1'b0;
    #1 check("rerst_pmodblock", block2, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (105) @(negedge clk);
    check("rerst_release", block2, 1'b1);
    base_pv = n_pv[0];
    nb = 8'h30;
    line(0, 4);
    repeat (8) @(negedge clk);
    check("midframe_no_strobe", n_pv[0] - base_pv, 0);
    frame_start(0);
    line(0, 4);
    repeat (8) @(negedge clk);
    check("next_frame_strobes", n_pv[0] - base_pv, 2);
    check("next_frame_h0", (log2_h.size() >= 2) ? log2_h[log2_h.size() - 2] : 99, 0);

`ifdef CAMERA_CAPTURE_DECIM_EN
    // 2x2 decimation on a 4x4 Y8 frame
    decim[2] = 1'b1;
    frame_start(2);
    nb = 8'h10;
    for (int l = 0; l < 4; l++) line(2, 4);
    pclk(2, 1'b1, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    check("decim_strobes", n_pv[2], 4);
    check("decim_frame_err", n_fe[2], 0);
    for (int n = 0; n < logd_h.size() && n < 4; n++) begin
      check($sformatf("decim_h%0d", n), logd_h[n], n % 2);
      check($sformatf("decim_v%0d", n), logd_v[n], n / 2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
